// File: rtl/ledger_mem_pkg.sv
// Shared types and default sizing for the ledger memory responder.
package ledger_mem_pkg;
  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT} state_e;

  localparam int DEF_DATA_W    = 48;
  localparam int DEF_ADDR_W    = 3;
  localparam int DEF_READ_LAT  = 7;
  localparam int DEF_WRITE_LAT = 7;

  function automatic int lat_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction
endpackage

// File: rtl/ledger_mem_responder_lat_counter.sv
// Access-latency counter: cleared on accept, counts while enabled, flags terminal count.
module lat_counter #(
  parameter int CNT_W = 3
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] term_i,
  output logic             tc_o
);
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clock) begin
    if (!resetn)    cnt_q <= '0;
    else if (clr_i) cnt_q <= '0;
    else if (en_i)  cnt_q <= cnt_q + 1'b1;
  end

  assign tc_o = en_i && (cnt_q == term_i);
endmodule

// File: rtl/ledger_mem_responder.sv
// Ledger memory responder: edge-triggered read/write with fixed access latency and a 1-deep read slot.
// Optional LEDGER_MEM_PARITY_EN adds a stored even-parity bit and a parity_err pulse on reads.
module ledger_mem_responder
  import ledger_mem_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int READ_LAT  = DEF_READ_LAT,
  parameter int WRITE_LAT = DEF_WRITE_LAT
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              write_enable,
  input  logic              load_registers,
  input  logic              access_type,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] mem_out,
  output logic              rd_valid,
  output logic              wr_ack,
  output logic              busy,
  output logic              overrun
`ifdef LEDGER_MEM_PARITY_EN
  , output logic            parity_err
`endif
);
  localparam int AW    = ADDR_W + 1;
  localparam int DEPTH = 2 ** AW;
  localparam int CNT_W = $clog2(lat_max(READ_LAT, WRITE_LAT) + 1);
  localparam logic [CNT_W-1:0] WR_TERM = CNT_W'(WRITE_LAT - 1);
  localparam logic [CNT_W-1:0] RD_TERM = CNT_W'(READ_LAT - 1);
`ifdef LEDGER_MEM_PARITY_EN
  localparam int MW = DATA_W + 1;
`else
  localparam int MW = DATA_W;
`endif

  logic [MW-1:0]     mem_q [DEPTH];
  state_e            state_q, state_d;
  logic              we_prev_q, ld_prev_q;
  logic [AW-1:0]     waddr_q, waddr_d, raddr_q, raddr_d, pend_addr_q, pend_addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, mem_out_q;
  logic              pend_q, pend_d, overrun_q, overrun_d;
  logic              rd_valid_q, wr_ack_q;
  logic              wr_edge, rd_edge, cnt_clr, tc, commit, rd_fire;
  logic [AW-1:0]     eff_addr;
  logic [MW-1:0]     wword;

  assign wr_edge  = write_enable & ~we_prev_q;
  assign rd_edge  = load_registers & ~ld_prev_q;
  assign eff_addr = {access_type, addr};
  assign busy     = (state_q != IDLE);

  lat_counter #(.CNT_W(CNT_W)) u_cnt (
    .clock  (clock),
    .resetn (resetn),
    .clr_i  (cnt_clr),
    .en_i   (busy),
    .term_i ((state_q == WR_WAIT) ? WR_TERM : RD_TERM),
    .tc_o   (tc)
  );

  always_comb begin
    state_d     = state_q;
    waddr_d     = waddr_q;
    wdata_d     = wdata_q;
    raddr_d     = raddr_q;
    pend_d      = pend_q;
    pend_addr_d = pend_addr_q;
    overrun_d   = overrun_q;
    cnt_clr     = 1'b0;
    commit      = 1'b0;
    rd_fire     = 1'b0;
    case (state_q)
      IDLE: begin
        if (wr_edge) begin
          state_d = WR_WAIT;
          waddr_d = eff_addr;
          wdata_d = data_in;
          cnt_clr = 1'b1;
          // Simultaneous read is parked and served right after the commit.
          if (rd_edge) begin
            pend_d      = 1'b1;
            pend_addr_d = eff_addr;
          end
        end else if (rd_edge) begin
          state_d = RD_WAIT;
          raddr_d = eff_addr;
          cnt_clr = 1'b1;
        end
      end
      RD_WAIT, WR_WAIT: begin
        if (wr_edge) overrun_d = 1'b1;
        if (tc) begin
          commit  = (state_q == WR_WAIT);
          rd_fire = (state_q == RD_WAIT);
          state_d = IDLE;
          if (pend_q) begin
            state_d = RD_WAIT;
            raddr_d = pend_addr_q;
            pend_d  = 1'b0;
            cnt_clr = 1'b1;
            if (rd_edge) overrun_d = 1'b1;
          end else if (rd_edge) begin
            // A read arriving on the terminal cycle takes the free slot and launches at once.
            state_d = RD_WAIT;
            raddr_d = eff_addr;
            cnt_clr = 1'b1;
          end
        end else if (rd_edge) begin
          if (pend_q) overrun_d = 1'b1;
          else begin
            pend_d      = 1'b1;
            pend_addr_d = eff_addr;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef LEDGER_MEM_PARITY_EN
  logic parity_err_q;
  assign wword      = {^wdata_q, wdata_q};
  assign parity_err = parity_err_q;
  always_ff @(posedge clock) begin
    if (!resetn) parity_err_q <= 1'b0;
    else         parity_err_q <= rd_fire & (^mem_q[raddr_q]);
  end
`else
  assign wword = wdata_q;
`endif

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q     <= IDLE;
      we_prev_q   <= 1'b0;
      ld_prev_q   <= 1'b0;
      waddr_q     <= '0;
      wdata_q     <= '0;
      raddr_q     <= '0;
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
      overrun_q   <= 1'b0;
      mem_out_q   <= '0;
      rd_valid_q  <= 1'b0;
      wr_ack_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      we_prev_q   <= write_enable;
      ld_prev_q   <= load_registers;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
      raddr_q     <= raddr_d;
      pend_q      <= pend_d;
      pend_addr_q <= pend_addr_d;
      overrun_q   <= overrun_d;
      rd_valid_q  <= rd_fire;
      wr_ack_q    <= commit;
      if (rd_fire) mem_out_q <= mem_q[raddr_q][DATA_W-1:0];
    end
  end

  // Storage is never cleared; a reset landing on the commit cycle suppresses the write.
  always_ff @(posedge clock) begin
    if (commit && resetn) mem_q[waddr_q] <= wword;
  end

  assign mem_out  = mem_out_q;
  assign rd_valid = rd_valid_q;
  assign wr_ack   = wr_ack_q;
  assign overrun  = overrun_q;
endmodule
